// File: rtl/edge_detect_multi.sv
// rtl/edge_detect_multi.sv - multi-channel synchronised, debounced edge detector with sticky flags, irq and event counter
module edge_detect_multi #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 3,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       sig,
    input  logic [2*N-1:0]     mode,
    input  logic [N-1:0]       irq_en,
    input  logic [N-1:0]       clr,
    input  logic               cnt_clr,
    output logic [N-1:0]       pulse,
    output logic [N-1:0]       sticky,
    output logic               irq,
    output logic [CNT_W-1:0]   event_cnt
);

    localparam int DW = $clog2(DEB_CYCLES) + 1;
    localparam int PW = $clog2(N + 1);
    localparam int SW = CNT_W + PW;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [SW-1:0] CNT_MAX  = SW'({CNT_W{1'b1}});

    logic [N-1:0]  sync_q [SYNC_STAGES];
    logic [N-1:0]  filt;
    logic [DW-1:0] deb_cnt [N];
    logic [N-1:0]  s;
    logic [N-1:0]  update;
    logic [N-1:0]  pulse_d;
    logic [PW-1:0] pop;
    logic [SW-1:0] cnt_sum;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= sig;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // An update is the cycle in which a differing level has persisted long enough.
    always_comb begin
        update  = '0;
        pulse_d = '0;
        for (int ch = 0; ch < N; ch++) begin
            update[ch]  = (s[ch] != filt[ch]) && (deb_cnt[ch] == DEB_LAST);
            pulse_d[ch] = update[ch] && (filt[ch] ? mode[2*ch+1] : mode[2*ch]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt <= '0;
            for (int ch = 0; ch < N; ch++) begin
                deb_cnt[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < N; ch++) begin
                if (s[ch] == filt[ch]) begin
                    deb_cnt[ch] <= '0;
                end else if (deb_cnt[ch] == DEB_LAST) begin
                    filt[ch]    <= s[ch];
                    deb_cnt[ch] <= '0;
                end else begin
                    deb_cnt[ch] <= deb_cnt[ch] + 1'b1;
                end
            end
        end
    end

    // Extra headroom bits let the sum overshoot before saturation is applied.
    always_comb begin
        pop = '0;
        for (int ch = 0; ch < N; ch++) begin
            pop = pop + PW'(pulse[ch]);
        end
        cnt_sum = (cnt_clr ? '0 : SW'(event_cnt)) + SW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse     <= '0;
            sticky    <= '0;
            irq       <= 1'b0;
            event_cnt <= '0;
        end else begin
            pulse     <= pulse_d;
            sticky    <= (sticky & ~clr) | pulse;
            irq       <= |(sticky & irq_en);
            event_cnt <= (cnt_sum > CNT_MAX) ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_edge_detect_multi.sv
// tb/tb_edge_detect_multi.sv - scoreboard bench for edge_detect_multi against a history-window model
module tb_edge_detect_multi;

    localparam int N     = 4;
    localparam int SYNC  = 2;
    localparam int DEB   = 3;
    localparam int CMAX  = 255;
    localparam int HD    = SYNC + DEB;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] sig;
    logic [2*N-1:0] mode;
    logic [N-1:0] irq_en;
    logic [N-1:0] clr;
    logic         cnt_clr;
    logic [N-1:0] pulse;
    logic [N-1:0] sticky;
    logic         irq;
    logic [7:0]   event_cnt;

    typedef struct {
        logic [N-1:0] pulse;
        logic [N-1:0] sticky;
        logic         irq;
        int           cnt;
    } rec_t;

    rec_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    edge_detect_multi #(.N(N), .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .sig(sig), .mode(mode), .irq_en(irq_en), .clr(clr),
        .cnt_clr(cnt_clr), .pulse(pulse), .sticky(sticky), .irq(irq), .event_cnt(event_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    endtask

    // Reference model: a level is accepted once the last DEB synchronised samples all disagree with it.
    initial begin
        logic [N-1:0] hist [HD];
        logic [N-1:0] m_filt, m_pulse, m_sticky, np, ns;
        logic         m_irq, ni;
        int           m_cnt, nc;
        bit           stable;
        rec_t         r;
        for (int j = 0; j < HD; j++) hist[j] = '0;
        m_filt = '0; m_pulse = '0; m_sticky = '0; m_irq = 1'b0; m_cnt = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int j = 0; j < HD; j++) hist[j] = '0;
                m_filt = '0; m_pulse = '0; m_sticky = '0; m_irq = 1'b0; m_cnt = 0;
            end else begin
                np = '0;
                for (int ch = 0; ch < N; ch++) begin
                    stable = 1'b1;
                    for (int j = 0; j < DEB; j++)
                        if (hist[SYNC-1+j][ch] == m_filt[ch]) stable = 1'b0;
                    if (stable) begin
                        np[ch] = (m_filt[ch] == 1'b0) ? mode[2*ch] : mode[2*ch+1];
                        m_filt[ch] = ~m_filt[ch];
                    end
                end
                ns = (m_sticky & ~clr) | m_pulse;
                ni = |(m_sticky & irq_en);
                nc = (cnt_clr ? 0 : m_cnt) + $countones(m_pulse);
                if (nc > CMAX) nc = CMAX;
                m_pulse = np; m_sticky = ns; m_irq = ni; m_cnt = nc;
                for (int j = HD - 1; j > 0; j--) hist[j] = hist[j-1];
                hist[0] = sig;
            end
            r.pulse = m_pulse; r.sticky = m_sticky; r.irq = m_irq; r.cnt = m_cnt;
            q.push_back(r);
        end
    end

    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                r = q.pop_front();
                chk("pulse", int'(pulse), int'(r.pulse));
                chk("sticky", int'(sticky), int'(r.sticky));
                chk("irq", int'(irq), int'(r.irq));
                chk("event_cnt", int'(event_cnt), r.cnt);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        rst = 1'b1; sig = '0; mode = '0; irq_en = '0; clr = '0; cnt_clr = 1'b0;
        step(3);
        rst = 1'b0;
        step(2);

        // Single rise on ch0 with irq enabled
        mode = 8'b00_00_00_01; irq_en = 4'b0001;
        sig[0] = 1'b1; step(10);

        // Short glitch on ch1, then a real rise
        mode[3:2] = 2'b11;
        sig[1] = 1'b1; step(2);
        sig[1] = 1'b0; step(8);
        sig[1] = 1'b1; step(8);

        // Fall-only on ch2, then off mode with tracking, then both
        mode[5:4] = 2'b10;
        sig[2] = 1'b1; step(8);
        sig[2] = 1'b0; step(8);
        mode[5:4] = 2'b00;
        sig[2] = 1'b1; step(8);
        sig[2] = 1'b0; step(8);
        sig[2] = 1'b1; step(8);
        mode[5:4] = 2'b11; step(8);

        // All channels together, repeated until the counter saturates
        mode = 8'hFF; irq_en = 4'hF;
        sig = 4'h0; step(8);
        for (int t = 0; t < 70; t++) begin
            sig = ~sig; step(8);
        end

        // Clear coincident with a new set on ch0; count clear coincident with pulses
        clr[0] = 1'b1;
        sig[0] = ~sig[0]; step(10);
        clr[0] = 1'b0;
        sig[1:0] = ~sig[1:0]; step(5);
        cnt_clr = 1'b1; step(1);
        cnt_clr = 1'b0; step(6);

        // Reset in the middle of a debounce on ch3
        sig[3] = ~sig[3]; step(4);
        rst = 1'b1; step(1);
        rst = 1'b0; sig = 4'b1000; step(10);

        // Random phase
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, N - 1);
                sig[k] = ~sig[k];
            end
            if ($urandom_range(0, 40) == 0) mode = 8'($urandom);
            if ($urandom_range(0, 40) == 0) irq_en = 4'($urandom);
            clr     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            cnt_clr = ($urandom_range(0, 30) == 0);
            rst     = ($urandom_range(0, 200) == 0);
            step(1);
        end
        rst = 1'b0;
        step(4);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
- Parametrised, multi-channel successor to the single-bit positive-edge detector.
- Each of N asynchronous input lines passes through a configurable synchroniser and a debounce filter. A per-channel mode then selects rising, falling, both or no edges.
- Outputs per channel: a one-cycle event pulse and a sticky pending flag. Shared outputs: a maskable interrupt and a saturating total event counter.
- Sits between raw external/status lines and the interrupt/status logic.

Parameters:
- N, 4, number of channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- DEB_CYCLES, 3, consecutive cycles a new level must persist before it is accepted (>=1; 1 = no filtering).
- CNT_W, 8, width of the total event counter (>=2).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- sig  in  N  raw asynchronous input lines.
- mode  in  2*N  per channel ch at bits [2ch+1:2ch]: 00 off, 01 rise, 10 fall, 11 both.
- irq_en  in  N  per-channel interrupt enable.
- clr  in  N  write-1-to-clear for sticky.
- cnt_clr  in  1  clears event_cnt.
- pulse  out  N  one-cycle event pulse, registered.
- sticky  out  N  pending-event flags.
- irq  out  1  registered OR of (sticky & irq_en).
- event_cnt  out  CNT_W  saturating count of all pulses.

Behaviour:
- Reset (rst=1 at a clk edge): all synchroniser flops, filtered level filt, debounce counters, pulse, sticky, irq and event_cnt go to 0. rst overrides every other input. It is legal mid-debounce: the partial count is discarded.
- Synchroniser: per-channel shift chain of SYNC_STAGES flops; its last stage is s[ch].
- Debounce (per channel, deb_cnt width clog2(DEB_CYCLES)+1):
  - if s==filt: deb_cnt<=0.
  - else if deb_cnt==DEB_CYCLES-1: filt<=s and deb_cnt<=0 (this is an "update" cycle).
  - else deb_cnt<=deb_cnt+1.
  - A glitch shorter than DEB_CYCLES synchronised cycles is never accepted; any return to s==filt restarts the count.
- Pulse:
  - pulse[ch]<=1 in an update cycle when the update direction matches mode (0->1 needs mode bit0, 1->0 needs mode bit1); otherwise pulse<=0.
  - Always exactly one cycle wide.
  - Mode is sampled in the update cycle. Mode 00 suppresses pulses, but filtering continues so filt stays tracked.
- Latency: counting the first clk edge that samples the new sig level as edge 1, pulse rises on edge SYNC_STAGES+DEB_CYCLES (defaults: edge 5) and falls on the next edge.
- Post-reset: filt=0, so a line held high through reset produces a rise event after the normal latency.
- Sticky: sticky[ch]<=(sticky[ch] & ~clr[ch]) | pulse[ch]. This is evaluated on the registered pulse, so sticky sets one cycle after pulse. If the set and the clear of the same channel fall in the same cycle, the set wins.
- irq: registered, one cycle after sticky.
- Event counter:
  - event_cnt increments by popcount(pulse) each cycle and saturates at 2^CNT_W-1; no wrap, even when the add would overshoot.
  - cnt_clr=1 sets event_cnt to popcount(pulse) for that cycle, so events in the clear cycle are not lost.
- Channels are fully independent. Simultaneous pulses on several channels are all counted.

Test Plan (N=4, SYNC_STAGES=2, DEB_CYCLES=3, CNT_W=8):
- mode=01 on ch0. Raise sig[0] and hold 10 cycles. Required: pulse[0] high on edge 5 only; sticky[0] set on edge 6; irq=1 on edge 7 with irq_en[0]=1; event_cnt=1.
- Glitch: sig[1] high for 2 cycles, then low, mode=11. Required: no pulse, sticky[1]=0, event_cnt unchanged. Then hold sig[1] high 3+ cycles: exactly one pulse.
- mode=10 on ch2, toggle sig[2] 0->1->0 with 8-cycle holds. Required: pulse only on the fall. mode=00 on the same toggles: no pulses, and filt tracks (verified by switching to 11 with no spurious pulse).
- All four channels rise together with mode=11. Required: four pulses in the same cycle and event_cnt += 4. Preload to 253 and repeat: event_cnt=255 and it stays 255.
- clr[0] asserted in the same cycle a new pulse on ch0 would set sticky. Required: sticky[0] remains 1. cnt_clr coincident with 2 pulses: event_cnt=2.
- rst asserted mid-debounce (deb_cnt=2) with sig[3]=1 held. Required: all outputs 0 next cycle; after rst is released, pulse[3] appears at the full latency of 5 edges.
